// File: rtl/counter_sequencer.sv
// Round-robin front end that shares one loadable up-counter between two requesters.
// It runs one LOAD or one INC burst at a time and never increments past all-ones.
module counter_sequencer #(
  parameter int WIDTH = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0,
  input  logic             op0,
  input  logic [WIDTH-1:0] arg0,
  input  logic             req1,
  input  logic             op1,
  input  logic [WIDTH-1:0] arg1,
  output logic             gnt0,
  output logic             gnt1,
  output logic             done,
  output logic             sat,
  output logic             busy,
  output logic             ld,
  output logic             inc,
  output logic [WIDTH-1:0] data_in,
  input  logic [WIDTH-1:0] data_out
);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_INC, S_DONE} state_t;

  state_t           r_state;
  logic             r_rr_ptr;
  logic             r_served;
  logic             r_gnt0;
  logic             r_gnt1;
  logic             r_done;
  logic             r_sat;
  logic             r_ld;
  logic [WIDTH-1:0] r_rem;
  logic [WIDTH-1:0] r_data_in;

  logic             w_pick1;
  logic             w_op;
  logic [WIDTH-1:0] w_arg;
  logic             w_at_max;

  // Requester 1 wins when alone, or when both ask and the pointer favours it.
  assign w_pick1  = req1 && (!req0 || r_rr_ptr);
  assign w_op     = w_pick1 ? op1 : op0;
  assign w_arg    = w_pick1 ? arg1 : arg0;
  assign w_at_max = (data_out == {WIDTH{1'b1}});

  assign inc     = (r_state == S_INC) && (r_rem != '0) && !w_at_max;
  assign busy    = (r_state != S_IDLE);
  assign gnt0    = r_gnt0;
  assign gnt1    = r_gnt1;
  assign done    = r_done;
  assign sat     = r_sat;
  assign ld      = r_ld;
  assign data_in = r_data_in;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= S_IDLE;
      r_rr_ptr  <= 1'b0;
      r_served  <= 1'b0;
      r_gnt0    <= 1'b0;
      r_gnt1    <= 1'b0;
      r_done    <= 1'b0;
      r_sat     <= 1'b0;
      r_ld      <= 1'b0;
      r_rem     <= '0;
      r_data_in <= '0;
    end else begin
      r_gnt0    <= 1'b0;
      r_gnt1    <= 1'b0;
      r_done    <= 1'b0;
      r_sat     <= 1'b0;
      r_ld      <= 1'b0;
      r_data_in <= '0;
      case (r_state)
        S_IDLE: begin
          if (req0 || req1) begin
            r_served <= w_pick1;
            r_gnt0   <= !w_pick1;
            r_gnt1   <= w_pick1;
            r_rem    <= w_arg;
            if (!w_op) begin
              r_state   <= S_LOAD;
              r_ld      <= 1'b1;
              r_data_in <= w_arg;
            end else begin
              r_state <= S_INC;
            end
          end
        end
        S_LOAD: begin
          r_state <= S_DONE;
          r_done  <= 1'b1;
        end
        S_INC: begin
          // An increment is issued exactly in the else branch, so rem tracks it.
          if (r_rem == '0) begin
            r_state <= S_DONE;
            r_done  <= 1'b1;
          end else if (w_at_max) begin
            r_state <= S_DONE;
            r_done  <= 1'b1;
            r_sat   <= 1'b1;
          end else begin
            r_rem <= r_rem - WIDTH'(1);
          end
        end
        S_DONE: begin
          r_state  <= S_IDLE;
          r_rr_ptr <= !r_served;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_counter_sequencer.sv
// Bench for counter_sequencer: emulates the counter, predicts each operation's
// cycle-by-cycle output timeline and compares every cycle, plus literal spot checks.
module tb_counter_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       req0, op0, req1, op1;
  logic [2:0] arg0, arg1;
  logic       gnt0, gnt1, done, sat, busy, ld, inc;
  logic [2:0] data_in;
  logic [2:0] cnt = 3'd0;

  counter_sequencer #(.WIDTH(3)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .op0(op0), .arg0(arg0),
    .req1(req1), .op1(op1), .arg1(arg1),
    .gnt0(gnt0), .gnt1(gnt1), .done(done), .sat(sat), .busy(busy),
    .ld(ld), .inc(inc), .data_in(data_in), .data_out(cnt)
  );

  always #5 clk = ~clk;

  // The shared counter: ld wins over inc, both take effect at the edge.
  always @(posedge clk) begin
    if (ld) cnt <= data_in;
    else if (inc) cnt <= cnt + 3'd1;
  end

  localparam int NCYC = 1024;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  bit       exp_gnt0 [NCYC];
  bit       exp_gnt1 [NCYC];
  bit       exp_done [NCYC];
  bit       exp_sat  [NCYC];
  bit       exp_busy [NCYC];
  bit       exp_ld   [NCYC];
  bit       exp_inc  [NCYC];
  bit [2:0] exp_din  [NCYC];

  int n_chk = 0;
  int n_fail = 0;
  int m_val = 0;
  bit m_rr = 1'b0;

  int last_gnt_cyc = 0, last_done_cyc = 0, last_sat = 0, inc_total = 0;
  int gnt_hist[$];

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0d expected %0d", nm, cyc, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (cyc < NCYC) begin
      chk("gnt0", gnt0, exp_gnt0[cyc]);
      chk("gnt1", gnt1, exp_gnt1[cyc]);
      chk("done", done, exp_done[cyc]);
      chk("busy", busy, exp_busy[cyc]);
      chk("ld", ld, exp_ld[cyc]);
      chk("inc", inc, exp_inc[cyc]);
      chk("data_in", data_in, exp_din[cyc]);
      if (exp_done[cyc]) chk("sat", sat, exp_sat[cyc]);
    end
    if (inc) chk("inc_at_max", (cnt == 3'd7) ? 1 : 0, 0);
    if (gnt0) begin gnt_hist.push_back(0); last_gnt_cyc = cyc; end
    if (gnt1) begin gnt_hist.push_back(1); last_gnt_cyc = cyc; end
    if (done) begin last_done_cyc = cyc; last_sat = sat; end
    if (inc) inc_total++;
  end

  // Timeline of one operation whose arbitration edge ends cycle c.
  task automatic plan(input int c, input bit w, input bit op, input int arg, output int len);
    int room, k;
    if (!op) begin
      exp_ld[c+1]  = 1'b1;
      exp_din[c+1] = arg[2:0];
      len   = 2;
      m_val = arg;
      exp_sat[c+2] = 1'b0;
    end else begin
      room = 7 - m_val;
      k    = (arg < room) ? arg : room;
      for (int i = 1; i <= k; i++) exp_inc[c+i] = 1'b1;
      len   = k + 2;
      exp_sat[c+len] = (arg > room);
      m_val = m_val + k;
    end
    if (w) exp_gnt1[c+1] = 1'b1;
    else   exp_gnt0[c+1] = 1'b1;
    exp_done[c+len] = 1'b1;
    for (int i = 1; i <= len; i++) exp_busy[c+i] = 1'b1;
    m_rr = !w;
  endtask

  // Entered and left at a negedge of an idle cycle.
  task automatic do_op(input bit r0, input bit o0, input int a0,
                       input bit r1, input bit o1, input int a1, input bit spur);
    int c, len;
    bit w;
    req0 = r0; op0 = o0; arg0 = a0[2:0];
    req1 = r1; op1 = o1; arg1 = a1[2:0];
    c = cyc;
    w = (r0 && r1) ? m_rr : r1;
    plan(c, w, w ? o1 : o0, w ? a1 : a0, len);
    @(negedge clk);
    if (w) req1 = 1'b0;
    else   req0 = 1'b0;
    if (spur) begin req1 = 1'b1; op1 = 1'b1; arg1 = 3'd7; end
    repeat (len) begin
      @(negedge clk);
      if (spur) req1 = 1'b0;
    end
  endtask

  initial begin
    int c, len, inc0;
    rst = 1'b0;
    req0 = 0; op0 = 0; arg0 = 0; req1 = 0; op1 = 0; arg1 = 0;
    repeat (2) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_gnt", {gnt0, gnt1}, 0);
    chk("rst_strobes", {ld, inc, done, sat}, 0);
    chk("rst_data_in", data_in, 0);
    rst = 1'b1;
    @(negedge clk);

    // LOAD 5
    do_op(1, 0, 5, 0, 0, 0, 0);
    chk("t1_value", cnt, 5);
    chk("t1_latency", last_done_cyc - last_gnt_cyc, 1);

    // INC 2 from 5 reaches exactly 7
    inc0 = inc_total;
    do_op(0, 0, 0, 1, 1, 2, 0);
    chk("t2_value", cnt, 7);
    chk("t2_incs", inc_total - inc0, 2);
    chk("t2_sat", last_sat, 0);
    chk("t2_latency", last_done_cyc - last_gnt_cyc, 3);

    // INC 6 from 5 saturates after two increments
    do_op(1, 0, 5, 0, 0, 0, 0);
    inc0 = inc_total;
    do_op(1, 1, 6, 0, 0, 0, 0);
    chk("t3_value", cnt, 7);
    chk("t3_incs", inc_total - inc0, 2);
    chk("t3_sat", last_sat, 1);

    // INC 0 leaves the counter alone
    inc0 = inc_total;
    do_op(0, 0, 0, 1, 1, 0, 0);
    chk("t5_value", cnt, 7);
    chk("t5_incs", inc_total - inc0, 0);
    chk("t5_latency", last_done_cyc - last_gnt_cyc, 1);
    chk("t5_sat", last_sat, 0);

    // A request raised and dropped while busy must never be granted
    do_op(1, 0, 3, 0, 0, 0, 1);
    do_op(1, 0, 1, 0, 0, 0, 0);
    chk("spur_value", cnt, 1);

    // Reset during an INC 4 burst after two increments
    inc0 = inc_total;
    req1 = 1'b1; op1 = 1'b1; arg1 = 3'd4;
    c = cyc;
    plan(c, 1'b1, 1'b1, 4, len);
    @(negedge clk);
    req1 = 1'b0;
    @(negedge clk);
    for (int i = c + 3; i <= c + len; i++) begin
      exp_inc[i] = 0; exp_busy[i] = 0; exp_done[i] = 0; exp_sat[i] = 0;
    end
    @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    chk("t6_inc_drop", inc, 0);
    chk("t6_busy_drop", busy, 0);
    chk("t6_gnt_drop", {gnt0, gnt1}, 0);
    m_val = 3;
    m_rr  = 1'b0;
    @(negedge clk);
    chk("t6_value", cnt, 3);
    chk("t6_incs", inc_total - inc0, 2);
    @(negedge clk);
    rst = 1'b1;
    gnt_hist.delete();
    @(negedge clk);

    // Both requesting: grants alternate from 0; lone requester back-to-back
    for (int i = 0; i < 4; i++) do_op(1, 0, 1 + i, 1, 0, 6 - i, 0);
    do_op(0, 0, 0, 1, 0, 2, 0);
    do_op(0, 0, 0, 1, 1, 1, 0);
    chk("t4_value", cnt, 3);
    chk("t4_ngrants", gnt_hist.size(), 6);
    if (gnt_hist.size() == 6) begin
      int exp_seq[6];
      exp_seq = '{0, 1, 0, 1, 1, 1};
      for (int i = 0; i < 6; i++) chk("t4_grant_order", gnt_hist[i], exp_seq[i]);
    end

    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
